// File: rtl/decode_stage_pkg.sv
// Shared definitions for the decode stage: RV64I opcodes, one-hot format bit
// positions, buffer occupancy states and the per-entry decode result.
package decode_stage_pkg;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam int FMT_R = 5;
    localparam int FMT_I = 4;
    localparam int FMT_S = 3;
    localparam int FMT_B = 2;
    localparam int FMT_U = 1;
    localparam int FMT_J = 0;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [5:0] fmt;
        logic       illegal;
    } dec_t;

    function automatic logic [5:0] fmt_onehot(input int idx);
        logic [5:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/decode_stage_format.sv
// Purpose: classify a 32-bit RV64I word into one-hot [r,i,s,b,u,j] or flag it illegal.
// Latency: purely combinational.
// Backpressure: none; no state.
module inst_format_decoder
    import decode_stage_pkg::*;
(
    input  logic [31:0] i_inst,
    output logic [5:0]  o_type,
    output logic        o_illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       unused_bits;

    assign opcode      = i_inst[6:0];
    assign funct3      = i_inst[14:12];
    assign unused_bits = ^{i_inst[31:15], i_inst[11:7]};

    always_comb begin
        o_type    = '0;
        o_illegal = 1'b0;
        case (opcode)
            OPC_LUI, OPC_AUIPC: o_type = fmt_onehot(FMT_U);
            OPC_JAL:            o_type = fmt_onehot(FMT_J);
            OPC_JALR: begin
                if (funct3 == 3'b000) o_type    = fmt_onehot(FMT_I);
                else                  o_illegal = 1'b1;
            end
            OPC_BRANCH: begin
                // funct3 010/011 are unassigned in the branch space
                if (funct3 != 3'b010 && funct3 != 3'b011) o_type    = fmt_onehot(FMT_B);
                else                                      o_illegal = 1'b1;
            end
            OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM32, OPC_MISC_MEM, OPC_SYSTEM:
                o_type = fmt_onehot(FMT_I);
            OPC_STORE: begin
                if (funct3 <= 3'b011) o_type    = fmt_onehot(FMT_S);
                else                  o_illegal = 1'b1;
            end
            OPC_OP, OPC_OP32:   o_type = fmt_onehot(FMT_R);
            default:            o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// Purpose: decode stage with 2-entry skid buffer; optional perf counters via DECODE_STAGE_PERF_EN.
// Latency: 1 cycle from input acceptance to output.
// Backpressure: o_ready registered (low only when both entries full); no path from i_ready.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0
)(
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [31:0]     i_inst,
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_flush,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [31:0]     o_inst,
    output logic [XLEN-1:0] o_pc,
    output logic [5:0]      o_type,
`ifdef DECODE_STAGE_PERF_EN
    output logic [31:0]     o_stall_cycles,
    output logic [15:0]     o_illegal_count,
`endif
    output logic            o_illegal
);

    state_t          state_q, state_d;
    logic [31:0]     main_inst_q, skid_inst_q;
    logic [XLEN-1:0] main_pc_q, skid_pc_q;
    dec_t            main_dec_q, skid_dec_q, in_dec;
    logic [5:0]      in_fmt;
    logic            in_illegal;
    logic            accept, out;
    logic            load_main_in, load_main_skid, load_skid;

    inst_format_decoder u_fmt (
        .i_inst    (i_inst),
        .o_type    (in_fmt),
        .o_illegal (in_illegal)
    );

    assign in_dec  = '{fmt: in_fmt, illegal: in_illegal};
    assign o_valid = (state_q != EMPTY);
    assign o_ready = (state_q != FULL);
    assign accept  = i_valid && o_ready;
    assign out     = o_valid && i_ready;

    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (i_flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (accept) begin
                    state_d      = ONE;
                    load_main_in = 1'b1;
                end
                ONE: begin
                    if (accept && out) begin
                        load_main_in = 1'b1;
                    end else if (accept) begin
                        state_d   = FULL;
                        load_skid = 1'b1;
                    end else if (out) begin
                        state_d = EMPTY;
                    end
                end
                FULL: if (out) begin
                    state_d        = ONE;
                    load_main_skid = 1'b1;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= EMPTY;
        else       state_q <= state_d;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            main_inst_q <= '0;
            main_pc_q   <= RESET_PC;
            main_dec_q  <= '0;
            skid_inst_q <= '0;
            skid_pc_q   <= '0;
            skid_dec_q  <= '0;
        end else begin
            if (load_main_in) begin
                main_inst_q <= i_inst;
                main_pc_q   <= i_pc;
                main_dec_q  <= in_dec;
            end else if (load_main_skid) begin
                main_inst_q <= skid_inst_q;
                main_pc_q   <= skid_pc_q;
                main_dec_q  <= skid_dec_q;
            end
            if (load_skid) begin
                skid_inst_q <= i_inst;
                skid_pc_q   <= i_pc;
                skid_dec_q  <= in_dec;
            end
        end
    end

    assign o_inst    = main_inst_q;
    assign o_pc      = main_pc_q;
    assign o_type    = main_dec_q.fmt;
    assign o_illegal = main_dec_q.illegal;

`ifdef DECODE_STAGE_PERF_EN
    // Counters survive flush so software sees totals across redirects.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_stall_cycles  <= '0;
            o_illegal_count <= '0;
        end else begin
            if (o_valid && !i_ready && o_stall_cycles != '1)
                o_stall_cycles <= o_stall_cycles + 32'd1;
            if (out && o_illegal && o_illegal_count != '1)
                o_illegal_count <= o_illegal_count + 16'd1;
        end
    end
`endif

endmodule
